// File: rtl/avalon_pwm_gen.sv
// Avalon-MM PWM generator with double-buffered period/duty and a hardware arm gate.
// Optional interrupt (CTRL.IE / CTRL.PEND, irq output) is enabled by defining PWM_GEN_IRQ_EN.
module avalon_pwm_gen #(
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned RST_PERIOD = 1000000,
    parameter int unsigned RST_DUTY   = 75000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        arm_in,
`ifdef PWM_GEN_IRQ_EN
    output logic        irq,
`endif
    output logic        pwm_out
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_DUTY   = 2'd2;
    localparam logic [1:0] ADDR_CNT    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PERIOD_RESET = CNT_W'(RST_PERIOD);
    localparam logic [CNT_W-1:0] DUTY_RESET   = CNT_W'(RST_DUTY);

    logic             en_q, en_d;
    logic             pol_q, pol_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] period_sh_q, period_sh_d;
    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pwm_q, pwm_d;
`ifdef PWM_GEN_IRQ_EN
    logic             ie_q, ie_d;
    logic             pend_q, pend_d;
`endif

    logic wr_en;
    logic run;
    logic boundary;
    logic active;
    logic wdata_unused;

    assign wr_en        = chipselect & ~write_n;
    assign run          = en_q & arm_in;
    assign wdata_unused = ^writedata;

    // A zero period is treated as a boundary every cycle so the shadows keep reloading.
    assign boundary = (period_sh_q == '0) || (cnt_q == (period_sh_q - CNT_ONE));
    assign active   = (period_sh_q != '0) && (cnt_q < duty_sh_q);

    always_comb begin
        en_d        = en_q;
        pol_d       = pol_q;
        period_d    = period_q;
        duty_d      = duty_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        cnt_d       = cnt_q;
        pwm_d       = pwm_q;
`ifdef PWM_GEN_IRQ_EN
        ie_d        = ie_q;
        pend_d      = pend_q;
`endif

        if (wr_en) begin
            case (address)
                ADDR_CTRL: begin
                    en_d  = writedata[0];
                    pol_d = writedata[1];
`ifdef PWM_GEN_IRQ_EN
                    ie_d  = writedata[2];
                    if (writedata[3]) begin
                        pend_d = 1'b0;
                    end
`endif
                end
                ADDR_PERIOD: period_d = writedata[CNT_W-1:0];
                ADDR_DUTY:   duty_d   = writedata[CNT_W-1:0];
                default: ;
            endcase
        end

        if (!run) begin
            cnt_d       = '0;
            period_sh_d = period_q;
            duty_sh_d   = duty_q;
            pwm_d       = pol_q;
        end else begin
            if (boundary) begin
                cnt_d       = '0;
                period_sh_d = period_q;
                duty_sh_d   = duty_q;
`ifdef PWM_GEN_IRQ_EN
                pend_d      = 1'b1;
`endif
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
            pwm_d = active ^ pol_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q        <= 1'b0;
            pol_q       <= 1'b0;
            period_q    <= PERIOD_RESET;
            duty_q      <= DUTY_RESET;
            period_sh_q <= PERIOD_RESET;
            duty_sh_q   <= DUTY_RESET;
            cnt_q       <= '0;
            pwm_q       <= 1'b0;
`ifdef PWM_GEN_IRQ_EN
            ie_q        <= 1'b0;
            pend_q      <= 1'b0;
`endif
        end else begin
            en_q        <= en_d;
            pol_q       <= pol_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_d;
`ifdef PWM_GEN_IRQ_EN
            ie_q        <= ie_d;
            pend_q      <= pend_d;
`endif
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[1:0] = {pol_q, en_q};
`ifdef PWM_GEN_IRQ_EN
                readdata[3:2] = {pend_q, ie_q};
`endif
            end
            ADDR_PERIOD: readdata[CNT_W-1:0] = period_q;
            ADDR_DUTY:   readdata[CNT_W-1:0] = duty_q;
            ADDR_CNT:    readdata[CNT_W-1:0] = cnt_q;
            default: ;
        endcase
    end

    assign pwm_out = pwm_q;
`ifdef PWM_GEN_IRQ_EN
    assign irq     = ie_q & pend_q;
`endif

endmodule

// File: tb/tb_avalon_pwm_gen.sv
// Directed bench for avalon_pwm_gen; IRQ steps are compiled in when PWM_GEN_IRQ_EN is defined.
module tb_avalon_pwm_gen;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        arm_in;
    logic        pwm_out;
`ifdef PWM_GEN_IRQ_EN
    logic        irq;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int k      = 0;
    logic [31:0] v;

    avalon_pwm_gen #(
        .CNT_W(20),
        .RST_PERIOD(1000000),
        .RST_DUTY(75000)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .arm_in(arm_in),
`ifdef PWM_GEN_IRQ_EN
        .irq(irq),
`endif
        .pwm_out(pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wr_setup(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_setup(a, d);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Advance one clock (completing any pending write), then check CNT and pwm_out.
    task automatic step(input int ec, input logic ep);
        logic [31:0] c;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd(2'd3, c);
        check("cnt", c, ec);
        check("pwm", {31'd0, pwm_out}, {31'd0, ep});
    endtask

    task automatic restart(input logic [31:0] p, input logic [31:0] d, input logic [31:0] c);
        logic [31:0] r;
        wr(2'd0, c & ~32'd1);
        wr(2'd1, p);
        wr(2'd2, d);
        wr(2'd0, c | 32'd8);
        k = 0;
        rd(2'd3, r);
        check("restart_cnt", r, 0);
        check("restart_pwm", {31'd0, pwm_out}, {31'd0, c[1]});
    endtask

    initial begin
        reset_n    = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        arm_in     = 1'b0;
        #1 reset_n = 1'b0;
        #10;
        check("rst_pwm", {31'd0, pwm_out}, 0);
        rd(2'd0, v); check("rst_ctrl", v, 0);
        rd(2'd1, v); check("rst_period", v, 1000000);
        rd(2'd2, v); check("rst_duty", v, 75000);
        rd(2'd3, v); check("rst_cnt", v, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // CTRL bits 2-3 exist only with the IRQ option; bit3 is write-1-to-clear.
        wr(2'd0, 32'hFFFF_FFFE);
        rd(2'd0, v);
`ifdef PWM_GEN_IRQ_EN
        check("ctrl_rb", v, 6);
`else
        check("ctrl_rb", v, 2);
`endif
        wr(2'd0, 32'd0);

        // Normal run: upper writedata bits are dropped from PERIOD.
        arm_in = 1'b1;
        wr(2'd1, 32'hFFF0_000A);
        rd(2'd1, v); check("period_trunc", v, 10);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'd1);
        k = 0;
        rd(2'd3, v); check("run_start_cnt", v, 0);
        check("run_start_pwm", {31'd0, pwm_out}, 0);
        repeat (25) begin k++; step(k % 10, ((k - 1) % 10) < 3); end

        // DUTY=6 written while cnt=5: remainder of this period keeps duty 3.
        wr_setup(2'd2, 32'd6);
        repeat (5) begin k++; step(k % 10, ((k - 1) % 10) < 3); end
        repeat (19) begin k++; step(k % 10, ((k - 1) % 10) < 6); end

        // DUTY=2 written on the cnt=9 cycle: shadow takes the old value, new one a period later.
        wr_setup(2'd2, 32'd2);
        repeat (11) begin k++; step(k % 10, ((k - 1) % 10) < 6); end
        repeat (10) begin k++; step(k % 10, ((k - 1) % 10) < 2); end

        restart(32'd10, 32'd0, 32'd1);
        repeat (12) begin k++; step(k % 10, 1'b0); end
        restart(32'd10, 32'd10, 32'd1);
        repeat (12) begin k++; step(k % 10, 1'b1); end
        restart(32'd10, 32'd15, 32'd1);
        repeat (12) begin k++; step(k % 10, 1'b1); end
        restart(32'd0, 32'd3, 32'd1);
        repeat (5) step(0, 1'b0);
        restart(32'd1, 32'd1, 32'd1);
        repeat (5) step(0, 1'b1);

        // Active-low output, then drop and restore the arm gate.
        restart(32'd10, 32'd3, 32'd3);
        repeat (15) begin k++; step(k % 10, (((k - 1) % 10) < 3) ^ 1'b1); end
        arm_in = 1'b0;
        repeat (3) step(0, 1'b1);
        wr_setup(2'd3, 32'd7);
        step(0, 1'b1);
        arm_in = 1'b1;
        k = 0;
        repeat (12) begin k++; step(k % 10, (((k - 1) % 10) < 3) ^ 1'b1); end

`ifdef PWM_GEN_IRQ_EN
        restart(32'd10, 32'd3, 32'd5);
        check("irq_init", {31'd0, irq}, 0);
        repeat (9) begin
            k++; step(k % 10, ((k - 1) % 10) < 3);
            check("irq_low", {31'd0, irq}, 0);
        end
        k++; step(k % 10, 1'b0);
        check("irq_rise", {31'd0, irq}, 1);
        wr_setup(2'd0, 32'd13);
        k++; step(k % 10, 1'b1);
        check("irq_clear", {31'd0, irq}, 0);
        repeat (8) begin k++; step(k % 10, ((k - 1) % 10) < 3); end
        check("irq_still_low", {31'd0, irq}, 0);
        wr_setup(2'd0, 32'd13);
        k++; step(k % 10, 1'b0);
        check("irq_set_wins", {31'd0, irq}, 1);
`endif

        // Asynchronous reset in the middle of an active pulse.
        restart(32'd10, 32'd3, 32'd1);
        step(1, 1'b1);
        step(2, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_pwm", {31'd0, pwm_out}, 0);
        rd(2'd0, v); check("async_rst_ctrl", v, 0);
        rd(2'd1, v); check("async_rst_period", v, 1000000);
        rd(2'd2, v); check("async_rst_duty", v, 75000);
        rd(2'd3, v); check("async_rst_cnt", v, 0);
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
